// File: rtl/vga_pkg.sv
// Shared types and constants for the menu text buffer.
package vga_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_SETXY   = 2'd1,
        OP_NEWLINE = 2'd2,
        OP_CLEAR   = 2'd3
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [6:0] BLANK_CODE = 7'h20;

endpackage

// File: rtl/text_ram.sv
// Character cell storage: one synchronous write port, one registered
// read-first read port, no reset so it maps onto block RAM.
module text_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/menu_text_buf.sv
// Text buffer for an on-screen menu: cursor-driven command writes,
// a one-cell-per-cycle clear sweep and a 1-cycle display read port.
module menu_text_buf
    import vga_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int CODE_W = 7,
    parameter logic [CODE_W-1:0] BLANK = CODE_W'(BLANK_CODE),
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int XY_W  = RW + CW,
    localparam int ARG_W = (XY_W > CODE_W) ? XY_W : CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XY_W-1:0]   char_xy,
    output logic [CODE_W-1:0] char_code,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ARG_W-1:0]  cmd_arg,
    output logic [XY_W-1:0]   cursor,
    output logic              busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int LW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [LW-1:0] CLR_LAST = LW'(CELLS - 1);

    function automatic logic [LW-1:0] lin(
        input logic [RW-1:0] r,
        input logic [CW-1:0] c
    );
        return LW'(r) * LW'(COLS) + LW'(c);
    endfunction

    state_e state_q, state_d;
    logic [LW-1:0] clr_q, clr_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic blank_q, blank_d;

    cmd_op_e op;
    logic [CW-1:0] rd_col, arg_col;
    logic [RW-1:0] rd_row, arg_row;
    logic oob;
    logic ram_we;
    logic [LW-1:0] ram_waddr, ram_raddr;
    logic [CODE_W-1:0] ram_wdata, ram_rdata;

    assign op      = cmd_op_e'(cmd_op);
    assign rd_col  = char_xy[CW-1:0];
    assign rd_row  = char_xy[XY_W-1:CW];
    assign arg_col = cmd_arg[CW-1:0];
    assign arg_row = cmd_arg[XY_W-1:CW];
    assign oob = (32'(rd_col) >= 32'(COLS)) || (32'(rd_row) >= 32'(ROWS));
    assign ram_raddr = oob ? '0 : lin(rd_row, rd_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && op == OP_CLEAR) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    clr_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Cursor and write-port steering; the sweep owns the RAM while busy.
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        blank_d   = oob;
        ram_we    = 1'b0;
        ram_waddr = lin(row_q, col_q);
        ram_wdata = cmd_arg[CODE_W-1:0];
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_q;
            ram_wdata = BLANK;
            col_d     = '0;
            row_d     = '0;
        end else if (cmd_valid) begin
            unique case (op)
                OP_WRITE: begin
                    ram_we = 1'b1;
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                OP_SETXY: begin
                    col_d = (32'(arg_col) > 32'(COLS - 1)) ? COL_MAX : arg_col;
                    row_d = (32'(arg_row) > 32'(ROWS - 1)) ? ROW_MAX : arg_row;
                end
                OP_NEWLINE: begin
                    col_d = '0;
                    row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                end
                OP_CLEAR: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q == ST_CLEAR);
        cursor    = {row_q, col_q};
        char_code = blank_q ? BLANK : ram_rdata;
    end

    text_ram #(
        .DEPTH(CELLS),
        .AW   (LW),
        .DW   (CODE_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_menu_text_buf.sv
// Scoreboard bench for menu_text_buf: a 16x16 instance and a 10x3 instance.
module tb_menu_text_buf;

    typedef struct {
        int         sel;
        int         what;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] a_xy = '0;
    logic [6:0] a_code;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [1:0] a_op = '0;
    logic [7:0] a_arg = '0;
    logic [7:0] a_cur;
    logic       a_busy;

    logic [5:0] b_xy = '0;
    logic [6:0] b_code;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_op = '0;
    logic [6:0] b_arg = '0;
    logic [5:0] b_cur;
    logic       b_busy;

    exp_t sb[$];
    int   chk_n = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    menu_text_buf u_a (
        .clk(clk), .rst(rst), .char_xy(a_xy), .char_code(a_code),
        .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
        .cmd_arg(a_arg), .cursor(a_cur), .busy(a_busy)
    );

    menu_text_buf #(.COLS(10), .ROWS(3)) u_b (
        .clk(clk), .rst(rst), .char_xy(b_xy), .char_code(b_code),
        .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
        .cmd_arg(b_arg), .cursor(b_cur), .busy(b_busy)
    );

    // Expected value of a DUT output as seen just after the coming edge.
    function automatic void ex(int sel, int what, logic [7:0] e, string nm);
        exp_t it;
        it.sel = sel;
        it.what = what;
        it.exp = e;
        it.name = nm;
        sb.push_back(it);
        chk_n++;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic a_cmd(input logic [1:0] op, input logic [7:0] arg);
        a_valid = 1'b1;
        a_op = op;
        a_arg = arg;
    endtask

    task automatic b_cmd(input logic [1:0] op, input logic [6:0] arg);
        b_valid = 1'b1;
        b_op = op;
        b_arg = arg;
    endtask

    // Monitor: pops the expectations queued for this edge and compares.
    initial begin
        int n;
        exp_t it;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            n = chk_n;
            chk_n = 0;
            #1;
            repeat (n) begin
                it = sb.pop_front();
                act = 8'h00;
                if (it.sel == 0) begin
                    case (it.what)
                        0: act = {1'b0, a_code};
                        1: act = a_cur;
                        2: act = {7'b0, a_ready};
                        default: act = {7'b0, a_busy};
                    endcase
                end else begin
                    case (it.what)
                        0: act = {1'b0, b_code};
                        1: act = {2'b0, b_cur};
                        2: act = {7'b0, b_ready};
                        default: act = {7'b0, b_busy};
                    endcase
                end
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h expected %0h at %0t",
                             it.name, act, it.exp, $time);
                end
            end
        end
    end

    initial begin
        step();
        ex(0, 0, 8'h20, "rst_code");
        ex(0, 1, 8'h00, "rst_cursor");
        ex(0, 2, 8'h00, "rst_ready");
        ex(0, 3, 8'h01, "rst_busy");
        ex(1, 0, 8'h20, "b_rst_code");
        ex(1, 3, 8'h01, "b_rst_busy");
        step();
        step();

        rst = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            ex(0, 3, (i == 256) ? 8'h00 : 8'h01, "sweep_busy");
            if (i == 256) ex(0, 2, 8'h01, "sweep_ready");
            if (i == 29) ex(1, 3, 8'h01, "b_sweep_busy29");
            if (i == 30) ex(1, 3, 8'h00, "b_sweep_busy30");
            step();
        end

        for (int a = 0; a < 256; a++) begin
            a_xy = 8'(a);
            ex(0, 0, 8'h20, "blank_read");
            step();
        end

        a_cmd(2'd1, 8'h23); ex(0, 1, 8'h23, "setxy_23"); step();
        a_cmd(2'd0, 8'h4D); ex(0, 1, 8'h24, "wr_M_cur"); step();
        a_cmd(2'd0, 8'h41); ex(0, 1, 8'h25, "wr_A_cur"); step();
        a_cmd(2'd0, 8'h54); ex(0, 1, 8'h26, "wr_T_cur"); step();
        a_valid = 1'b0;
        a_xy = 8'h23; ex(0, 0, 8'h4D, "rd_23"); step();
        a_xy = 8'h24; ex(0, 0, 8'h41, "rd_24"); step();
        a_xy = 8'h25; ex(0, 0, 8'h54, "rd_25"); step();
        a_xy = 8'h26; ex(0, 0, 8'h20, "rd_26"); step();

        a_cmd(2'd1, 8'hFF); ex(0, 1, 8'hFF, "setxy_ff"); step();
        a_cmd(2'd0, 8'h41); ex(0, 1, 8'h00, "wrap_cur"); step();
        a_valid = 1'b0;
        a_xy = 8'hFF; ex(0, 0, 8'h41, "rd_ff"); step();
        a_cmd(2'd1, 8'hF3); ex(0, 1, 8'hF3, "setxy_f3"); step();
        a_cmd(2'd2, 8'h00); ex(0, 1, 8'h00, "nl_wrap"); step();
        a_cmd(2'd1, 8'h35); ex(0, 1, 8'h35, "setxy_35"); step();
        a_cmd(2'd2, 8'h00); ex(0, 1, 8'h40, "nl_35"); step();

        a_cmd(2'd0, 8'h55);
        a_xy = 8'h40;
        ex(0, 0, 8'h20, "rw_same_old");
        ex(0, 1, 8'h41, "rw_same_cur");
        step();
        a_valid = 1'b0;
        ex(0, 0, 8'h55, "rw_same_new"); step();

        a_cmd(2'd3, 8'h00);
        ex(0, 2, 8'h00, "clr_ready0");
        ex(0, 3, 8'h01, "clr_busy0");
        step();
        a_cmd(2'd0, 8'h77);
        for (int i = 1; i <= 256; i++) begin
            ex(0, 2, (i == 256) ? 8'h01 : 8'h00, "clr_ready");
            if (i == 128 || i == 256) ex(0, 1, 8'h00, "clr_cursor");
            step();
        end
        ex(0, 1, 8'h01, "held_wr_cur"); step();
        a_valid = 1'b0;
        a_xy = 8'h00; ex(0, 0, 8'h77, "held_wr_rd"); step();
        a_xy = 8'h23; ex(0, 0, 8'h20, "clr_rd_23"); step();
        a_xy = 8'h40; ex(0, 0, 8'h20, "clr_rd_40"); step();

        b_cmd(2'd1, 7'h12); ex(1, 1, 8'h12, "b_setxy_12"); step();
        b_cmd(2'd0, 7'h33); ex(1, 1, 8'h13, "b_wr_cur"); step();
        b_valid = 1'b0;
        b_xy = 6'h12; ex(1, 0, 8'h33, "b_rd_12"); step();
        b_xy = 6'h0C; ex(1, 0, 8'h20, "b_rd_col12"); step();
        b_xy = 6'h0F; ex(1, 0, 8'h20, "b_rd_col15"); step();
        b_xy = 6'h32; ex(1, 0, 8'h20, "b_rd_row3"); step();
        b_cmd(2'd1, 7'h3F); ex(1, 1, 8'h29, "b_clamp"); step();
        b_cmd(2'd0, 7'h44); ex(1, 1, 8'h00, "b_wrap"); step();
        b_valid = 1'b0;
        b_xy = 6'h29; ex(1, 0, 8'h44, "b_rd_29"); step();
        b_cmd(2'd1, 7'h09); ex(1, 1, 8'h09, "b_setxy_09"); step();
        b_cmd(2'd0, 7'h11); ex(1, 1, 8'h10, "b_col_wrap"); step();
        b_cmd(2'd1, 7'h15); ex(1, 1, 8'h15, "b_setxy_15"); step();
        b_cmd(2'd2, 7'h00); ex(1, 1, 8'h20, "b_nl"); step();
        b_cmd(2'd2, 7'h00); ex(1, 1, 8'h00, "b_nl_wrap"); step();
        b_valid = 1'b0;
        b_xy = 6'h09; ex(1, 0, 8'h11, "b_rd_09"); step();

        step();
        step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/menu_text_buf.md
MENU_TEXT_BUF -- requirements
Module: menu_text_buf

Interface
REQ-001 The block SHALL have parameter COLS, default 16, meaning text columns (1..256).
REQ-002 The block SHALL have parameter ROWS, default 16, meaning text rows (1..256).
REQ-003 The block SHALL have parameter CODE_W, default 7, meaning character-code width.
REQ-004 The block SHALL have parameter BLANK, default 7'h20, meaning the fill code used by clear.
REQ-005 The block SHALL use derived widths CW = $clog2(COLS), RW = $clog2(ROWS) and XY_W = RW+CW, each with a minimum of 1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port char_xy, input, XY_W bits: read address {row, col}, row in the upper RW bits.
REQ-009 The block SHALL have port char_code, output, CODE_W bits: registered read data.
REQ-010 The block SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-011 The block SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-012 The block SHALL have port cmd_op, input, 2 bits: WRITE=0, SETXY=1, NEWLINE=2, CLEAR=3.
REQ-013 The block SHALL have port cmd_arg, input, max(XY_W, CODE_W) bits: the character code or the {row, col} argument.
REQ-014 The block SHALL have port cursor, output, XY_W bits: current write position {row, col}.
REQ-015 The block SHALL have port busy, output, 1 bit: high while a clear is in progress.

Function
REQ-016 Reads SHALL have exactly 1-cycle latency: char_code at cycle n+1 is the cell addressed by char_xy at cycle n.
REQ-017 A read with col >= COLS or row >= ROWS SHALL return BLANK.
REQ-018 A read and a write to the same cell in the same cycle SHALL return the old contents (read-first); the new value is visible from the next read onward.
REQ-019 The FSM SHALL have two states: IDLE and CLEAR.
REQ-020 In IDLE, cmd_ready SHALL be 1. In CLEAR, cmd_ready SHALL be 0 and busy SHALL be 1.
REQ-021 A WRITE command SHALL store cmd_arg[CODE_W-1:0] at cursor and then advance cursor.
REQ-022 Cursor advance: col+1; if col == COLS-1 then col=0 and row+1; if additionally row == ROWS-1 then cursor=0 (wrap-around).
REQ-023 A SETXY command SHALL load cursor from cmd_arg[XY_W-1:0], clamping col to COLS-1 and row to ROWS-1.
REQ-024 A NEWLINE command SHALL set col=0 and row+1, wrapping to row 0 after ROWS-1.
REQ-025 A CLEAR command SHALL move IDLE->CLEAR and write BLANK to one cell per cycle, in linear order from cell 0.
REQ-026 CLEAR SHALL take exactly COLS*ROWS cycles, then return to IDLE with cursor=0.
REQ-027 Reads SHALL remain serviced during CLEAR.
REQ-028 Commands presented while cmd_ready=0 SHALL be ignored and not queued; the source holds cmd_valid.
REQ-029 Cell storage SHALL be COLS*ROWS entries of CODE_W bits, addressed by linear index row*COLS+col.

Reset
REQ-030 On rst, the block SHALL set char_code=BLANK, cursor=0, cmd_ready=0 and busy=1, and enter CLEAR.
REQ-031 After rst deasserts, the buffer SHALL be fully BLANK after COLS*ROWS cycles.
REQ-032 Cell storage itself SHALL not be reset; it is cleared only by the CLEAR sweep.
REQ-033 rst asserted mid-CLEAR or mid-command SHALL abort the operation and restart the sweep at cell 0.

Structure
REQ-034 vga_pkg SHALL hold the cmd_op enum typedef (WRITE/SETXY/NEWLINE/CLEAR) and the default BLANK code constant.
REQ-035 Storage SHALL be a sub-module text_ram, with one synchronous write port and one registered read port, inferring block RAM.
REQ-036 The FSM, cursor logic and clear counter SHALL reside in menu_text_buf.

Verification
REQ-037 Release rst and wait 256 cycles: every char_xy 0x00..0xFF reads 7'h20, and busy falls at cycle 256.
REQ-038 SETXY 0x23, then WRITE 'M','A','T' (7'h4D, 7'h41, 7'h54): cells 0x23..0x25 read back these codes and cursor=0x26.
REQ-039 SETXY 0xFF, then WRITE 7'h41: cell 0xFF=7'h41 and cursor wraps to 0x00; NEWLINE from 0xF3 gives 0x00.
REQ-040 Read 0x40 in the same cycle as a WRITE to 0x40 of 7'h55: char_code shows the old value, and the next read shows 7'h55.
REQ-041 CLEAR, then a WRITE held valid during the sweep: cmd_ready stays 0 for 256 cycles, the WRITE is accepted on the first IDLE cycle, and it lands at cursor 0x00.
REQ-042 With COLS=10, ROWS=3, read col=12: the result is BLANK, and WRITE at {2,9} wraps cursor to {0,0}.
